// File: rtl/mult_pkg.sv
// Shared types and constant helpers for the pipelined Wallace-tree multiplier.
package mult_pkg;

  localparam int unsigned TAG_W_MAX = 16;

  // Per-stage control that travels alongside the datapath
  typedef struct packed {
    logic                 valid;
    logic                 is_signed;
    logic [TAG_W_MAX-1:0] tag;
  } stage_ctl_t;

  function automatic int unsigned csa_next_rows(input int unsigned n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int unsigned csa_rows_at(input int unsigned n0, input int unsigned lvl);
    int unsigned n;
    n = n0;
    for (int unsigned i = 0; i < lvl; i++) n = csa_next_rows(n);
    return n;
  endfunction

  function automatic int unsigned csa_levels(input int unsigned n0);
    int unsigned n;
    int unsigned lv;
    n  = n0;
    lv = 0;
    while (n > 2) begin
      n  = csa_next_rows(n);
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 carry-save compressors across a W-bit word.
module csa_row #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage signed/unsigned multiplier: operand capture, Wallace reduction, final add.
module wallace_mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITS-1:0]    in_a,
  input  logic [BITS-1:0]    in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*BITS-1:0]  out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned PW     = 2 * BITS;
  localparam int unsigned ROWS   = BITS;
  localparam int unsigned LEVELS = csa_levels(ROWS);

  stage_ctl_t      s1_ctl;
  stage_ctl_t      s2_ctl;
  logic [BITS-1:0] s1_a;
  logic [BITS-1:0] s1_b;
  logic [PW-1:0]   s2_sum;
  logic [PW-1:0]   s2_carry;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp [ROWS];
  logic            adv;

  // Global stall: everything holds while a result waits on downstream
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (adv) begin
      s1_ctl.valid <= in_valid;
      if (in_valid) begin
        s1_ctl.is_signed <= in_signed;
        s1_ctl.tag       <= TAG_W_MAX'(in_tag);
        s1_a             <= in_a;
        s1_b             <= in_b;
      end
    end
  end

  // Signed mode negates the top row as ~row and adds the +1 in the final adder
  always_comb begin
    pp    = '{default: '0};
    a_ext = {{BITS{s1_ctl.is_signed & s1_a[BITS-1]}}, s1_a};
    for (int i = 0; i < int'(BITS) - 1; i++) begin
      pp[i] = s1_b[i] ? (a_ext << i) : '0;
    end
    pp[BITS-1] = s1_b[BITS-1] ? (a_ext << (BITS - 1)) : '0;
    if (s1_ctl.is_signed) pp[BITS-1] = ~pp[BITS-1];
  end

  for (genvar l = 0; l < int'(LEVELS); l++) begin : g_lvl
    localparam int unsigned N_IN  = csa_rows_at(ROWS, l);
    localparam int unsigned N_GRP = N_IN / 3;
    localparam int unsigned N_OUT = csa_next_rows(N_IN);

    logic [PW-1:0] rin  [N_IN];
    logic [PW-1:0] rout [N_OUT];

    if (l == 0) begin : g_src
      assign rin = pp;
    end else begin : g_src
      assign rin = g_lvl[l-1].rout;
    end

    for (genvar g = 0; g < int'(N_GRP); g++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .x     (rin[3*g]),
        .y     (rin[3*g+1]),
        .z     (rin[3*g+2]),
        .sum   (rout[2*g]),
        .carry (rout[2*g+1])
      );
    end

    // Rows left over after grouping by three pass straight through
    for (genvar k = 0; k < int'(N_IN % 3); k++) begin : g_pass
      assign rout[2*N_GRP+k] = rin[3*N_GRP+k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ctl   <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (adv) begin
      s2_ctl <= s1_ctl;
      if (s1_ctl.valid) begin
        s2_sum   <= g_lvl[LEVELS-1].rout[0];
        s2_carry <= g_lvl[LEVELS-1].rout[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_ctl.valid;
      if (s2_ctl.valid) begin
        out_prod <= s2_sum + s2_carry + PW'(s2_ctl.is_signed);
        out_tag  <= s2_ctl.tag[TAG_W-1:0];
      end
    end
  end

  // Tag bits above TAG_W are zero padding
  a_tag_pad: assert property (@(posedge clk) disable iff (rst) (s2_ctl.tag >> TAG_W) == '0);

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter BITS, default 32: operand width; legal range 4..64.
REQ-002 SHALL have parameter TAG_W, default 4: width of the user tag carried alongside each operation.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands, mode and tag are presented.
REQ-006 SHALL have port in_ready, output, 1: block accepts the presented operation this cycle.
REQ-007 SHALL have ports in_a and in_b, input, BITS each: multiplicand and multiplier.
REQ-008 SHALL have port in_signed, input, 1: 1 = two's-complement operands, 0 = unsigned operands.
REQ-009 SHALL have port in_tag, input, TAG_W: opaque tag returned with the result.
REQ-010 SHALL have port out_valid, output, 1: a result is presented.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_prod, output, 2*BITS: full-width product.
REQ-013 SHALL have port out_tag, output, TAG_W: tag of the presented result.

Function
REQ-014 SHALL have three register stages:
- S1: operand capture.
- S2: partial-product generation and carry-save 3:2 reduction down to a sum/carry pair.
- S3: final carry-propagate add.
REQ-015 SHALL deliver an accepted operation on out_valid exactly 3 cycles after acceptance when out_ready stays high.
REQ-016 SHALL accept an operation on a cycle with in_valid && in_ready, and complete a result on a cycle with out_valid && out_ready.
REQ-017 SHALL sustain a throughput of one operation per cycle with no bubbles while out_ready = 1.
REQ-018 SHALL, when out_valid && !out_ready, stall the whole pipeline: every stage holds its contents and in_ready = 0 in the same cycle (combinational from out_ready).
REQ-019 SHALL keep out_prod and out_tag stable while out_valid && !out_ready.
REQ-020 SHALL ignore in_a, in_b, in_signed and in_tag whenever in_valid = 0 or in_ready = 0.
REQ-021 SHALL track a per-stage valid bit; empty stages SHALL advance even during a stall so bubbles collapse.
- Consequence: in_ready = !(S3 valid && !out_ready) only if S1 and S2 cannot absorb the input; the simple global-stall form of REQ-018 is acceptable.
REQ-022 SHALL, in unsigned mode, return out_prod = a*b exactly; no overflow is possible at 2*BITS.
REQ-023 SHALL, in signed mode, return the exact two's-complement product in 2*BITS, using sign-extended partial products, including the case (-2^(BITS-1))^2.
REQ-024 SHALL build every reduction level from 3:2 compressors, where sum = x^y^z and carry = majority(x,y,z) shifted left one place; leftover rows pass to the next level unchanged.
REQ-025 SHALL keep in_signed and in_tag aligned with their own operation through every stage.

Reset
REQ-026 SHALL, while rst = 1, clear all stage valid bits, so out_valid = 0, out_prod = 0, out_tag = 0 and in_ready = 0.
REQ-027 SHALL raise in_ready = 1 on the first cycle after rst deasserts.
REQ-028 SHALL discard any in-flight operation when rst is asserted mid-operation; no stale result SHALL appear after reset.

Structure
REQ-029 SHALL place the following in shared package mult_pkg:
- localparam-style helper functions for the reduction-level count;
- a struct type carrying {valid, signed, tag}.
REQ-030 SHALL implement the 3:2 compressor row as the single sub-module csa_row, parameterised by width, instantiated per tree level via generate.

Verification (BITS=8, TAG_W=4)
REQ-031 Unsigned: a=0xFF, b=0xFF, tag=3 -> out_prod=0xFE01, out_tag=3, exactly 3 cycles after acceptance.
REQ-032 Signed: a=0x80, b=0x80 -> 0x4000; a=0xFF, b=0x01 -> 0xFFFF; a=0x7F, b=0x80 -> 0xC080.
REQ-033 Streaming: 256 back-to-back random operations of mixed mode with out_ready=1 -> one result per cycle, results in order, all match a reference model.
REQ-034 Backpressure: continuous input with out_ready held low 5 cycles mid-stream -> in_ready low during the stall, output held stable, no loss or duplication, order preserved.
REQ-035 Reset mid-flight: rst pulsed for 1 cycle with 3 operations in flight -> zero results emitted after reset, next accepted operation correct at latency 3.
